// File: rtl/clint_mtimer_pkg.sv
// clint_mtimer_pkg: shared constants and types for the CLINT timer.
// Register map, control word layout and handshake states.
package clint_mtimer_pkg;

   localparam logic [15:0] MsipBase     = 16'h0000;
   localparam logic [15:0] MtimecmpBase = 16'h4000;
   localparam logic [15:0] MtimeLo      = 16'hBFF8;
   localparam logic [15:0] MtimeHi      = 16'hBFFC;
   localparam logic [15:0] CtrlAddr     = 16'hC000;

   localparam int PrescaleMaxW = 16;

   typedef struct packed {
      logic [PrescaleMaxW-1:0] prescale;
      logic                    src;
      logic                    en;
   } ctrl_t;

   typedef enum logic {
      IDLE,
      RESP
   } state_e;

endpackage

// File: rtl/clint_mtimer_tick.sv
// clint_mtimer_tick: rtc synchroniser, edge detect and prescaler.
// Emits a single-cycle inc pulse for each mtime step.
module clint_mtimer_tick #(
   parameter int SyncStages = 2,
   parameter int PrescaleW  = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 rtc_i,
   input  logic                 en_i,
   input  logic                 src_i,
   input  logic                 clear_i,
   input  logic [PrescaleW-1:0] prescale_i,
   output logic                 inc_o
);

   logic [SyncStages-1:0] sync_q;
   logic                  rtc_q;
   logic                  tick;
   logic [PrescaleW-1:0]  cnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q <= '0;
         rtc_q  <= 1'b0;
      end else begin
         sync_q <= {sync_q[SyncStages-2:0], rtc_i};
         rtc_q  <= sync_q[SyncStages-1];
      end
   end

   assign tick  = src_i | (sync_q[SyncStages-1] & ~rtc_q);
   assign inc_o = en_i & tick & (cnt_q == prescale_i);

   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         cnt_q <= '0;
      end else if (en_i && tick) begin
         cnt_q <= inc_o ? '0 : cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/clint_mtimer.sv
// clint_mtimer: core-local timer and software interrupt controller.
// Register port, mtime/mtimecmp/msip storage and registered irq lines.
module clint_mtimer
   import clint_mtimer_pkg::*;
#(
   parameter int NumHarts      = 33,
   parameter int SyncStages    = 2,
   parameter int PrescaleW     = 16,
   parameter int ResetPrescale = 0
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                req_valid_i,
   output logic                req_ready_o,
   input  logic                req_write_i,
   input  logic [15:0]         req_addr_i,
   input  logic [31:0]         req_wdata_i,
   output logic                rsp_valid_o,
   input  logic                rsp_ready_i,
   output logic [31:0]         rsp_rdata_o,
   output logic                rsp_error_o,
   input  logic                rtc_i,
   output logic [NumHarts-1:0] timer_irq_o,
   output logic [NumHarts-1:0] ipi_o
);

   localparam int IdxW = (NumHarts > 1) ? $clog2(NumHarts) : 1;
   localparam logic [15:0] PsMask = 16'((32'd1 << PrescaleW) - 32'd1);

   state_e state_q, state_d;
   ctrl_t  ctrl;

   logic [63:0]         mtime;
   logic [63:0]         mtimecmp [NumHarts];
   logic [NumHarts-1:0] msip;

   logic            accept, wr_en, inc;
   logic            aligned, sel_any;
   logic            sel_msip, sel_cmp, sel_lo, sel_hi, sel_ctrl;
   logic [15:0]     msip_off, cmp_off;
   logic [IdxW-1:0] msip_idx, cmp_idx;
   logic [31:0]     rd_data;

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      req_ready_o = 1'b0;
      rsp_valid_o = 1'b0;
      unique case (state_q)
         IDLE: begin
            req_ready_o = 1'b1;
            if (req_valid_i) state_d = RESP;
         end
         RESP: begin
            rsp_valid_o = 1'b1;
            if (rsp_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign accept = req_valid_i & req_ready_o;
   assign wr_en  = accept & req_write_i;

   // Region offsets wrap below their base, so a single upper bound suffices.
   assign aligned  = req_addr_i[1:0] == 2'b00;
   assign msip_off = req_addr_i - MsipBase;
   assign cmp_off  = req_addr_i - MtimecmpBase;
   assign msip_idx = msip_off[2 +: IdxW];
   assign cmp_idx  = cmp_off[3 +: IdxW];

   assign sel_msip = aligned && (32'(msip_off) < 32'(4 * NumHarts));
   assign sel_cmp  = aligned && (32'(cmp_off) < 32'(8 * NumHarts));
   assign sel_lo   = req_addr_i == MtimeLo;
   assign sel_hi   = req_addr_i == MtimeHi;
   assign sel_ctrl = req_addr_i == CtrlAddr;
   assign sel_any  = sel_msip | sel_cmp | sel_lo | sel_hi | sel_ctrl;

   always_comb begin
      rd_data = '0;
      unique case (1'b1)
         sel_msip: rd_data = {31'b0, msip[msip_idx]};
         sel_cmp:  rd_data = cmp_off[2] ? mtimecmp[cmp_idx][63:32]
                                        : mtimecmp[cmp_idx][31:0];
         sel_lo:   rd_data = mtime[31:0];
         sel_hi:   rd_data = mtime[63:32];
         sel_ctrl: rd_data = {ctrl.prescale, 14'b0, ctrl.src, ctrl.en};
         default:  rd_data = '0;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rsp_rdata_o <= '0;
         rsp_error_o <= 1'b0;
      end else if (accept) begin
         rsp_rdata_o <= (req_write_i || !sel_any) ? '0 : rd_data;
         rsp_error_o <= ~sel_any;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ctrl.en       <= 1'b1;
         ctrl.src      <= 1'b0;
         ctrl.prescale <= 16'(ResetPrescale) & PsMask;
      end else if (wr_en && sel_ctrl) begin
         ctrl.en       <= req_wdata_i[0];
         ctrl.src      <= req_wdata_i[1];
         ctrl.prescale <= req_wdata_i[31:16] & PsMask;
      end
   end

   clint_mtimer_tick #(
      .SyncStages (SyncStages),
      .PrescaleW  (PrescaleW)
   ) u_tick (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .rtc_i      (rtc_i),
      .en_i       (ctrl.en),
      .src_i      (ctrl.src),
      .clear_i    (wr_en & sel_ctrl),
      .prescale_i (ctrl.prescale[PrescaleW-1:0]),
      .inc_o      (inc)
   );

   // A bus write to either half drops a coincident increment.
   always_ff @(posedge clk_i) begin
      if (rst_i)                mtime         <= '0;
      else if (wr_en && sel_lo) mtime[31:0]   <= req_wdata_i;
      else if (wr_en && sel_hi) mtime[63:32]  <= req_wdata_i;
      else if (inc)             mtime         <= mtime + 64'd1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < NumHarts; i++) mtimecmp[i] <= '1;
      end else if (wr_en && sel_cmp) begin
         if (cmp_off[2]) mtimecmp[cmp_idx][63:32] <= req_wdata_i;
         else            mtimecmp[cmp_idx][31:0]  <= req_wdata_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i)                  msip           <= '0;
      else if (wr_en && sel_msip) msip[msip_idx] <= req_wdata_i[0];
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         timer_irq_o <= '0;
         ipi_o       <= '0;
      end else begin
         for (int i = 0; i < NumHarts; i++) begin
            timer_irq_o[i] <= mtime >= mtimecmp[i];
         end
         ipi_o <= msip;
      end
   end

endmodule

// File: tb/tb_clint_mtimer.sv
// tb_clint_mtimer: directed and randomized checks of clint_mtimer
// against a register-level reference model.
module tb_clint_mtimer;

   localparam int N = 33;
   localparam int S = 2;
   localparam logic [15:0] CTRL = 16'hC000;
   localparam logic [15:0] MLO  = 16'hBFF8;
   localparam logic [15:0] MHI  = 16'hBFFC;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid, req_ready, req_write;
   logic [15:0]   req_addr;
   logic [31:0]   req_wdata;
   logic          rsp_valid, rsp_ready, rsp_error;
   logic [31:0]   rsp_rdata;
   logic          rtc;
   logic [N-1:0]  timer_irq, ipi;

   clint_mtimer dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .req_write_i (req_write),
      .req_addr_i  (req_addr),
      .req_wdata_i (req_wdata),
      .rsp_valid_o (rsp_valid),
      .rsp_ready_i (rsp_ready),
      .rsp_rdata_o (rsp_rdata),
      .rsp_error_o (rsp_error),
      .rtc_i       (rtc),
      .timer_irq_o (timer_irq),
      .ipi_o       (ipi)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   logic [63:0]  m_mtime;
   logic [63:0]  m_cmp [N];
   logic [N-1:0] m_msip;
   int           ec;
   int           ps;
   logic [N-1:0] snap_ipi;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] cmp_addr(input int i, input int hi);
      return 16'(32'h4000 + 8 * i + 4 * hi);
   endfunction

   function automatic logic [N-1:0] irq_model(input logic [63:0] mt);
      logic [N-1:0] v;
      for (int i = 0; i < N; i++) v[i] = mt >= m_cmp[i];
      return v;
   endfunction

   // mtime after edge e of a clk-sourced run anchored at ctrl write edge ec
   function automatic logic [63:0] mt_at(input int e);
      return m_mtime + 64'((e - ec) / (ps + 1));
   endfunction

   task automatic bus(input logic wr, input logic [15:0] a,
                      input logic [31:0] wd, output logic [31:0] rd,
                      output logic er, output int acc);
      int n;
      @(negedge clk);
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = a;
      req_wdata = wd;
      n = 0;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("req_ready_wait", 64'(n < 20), 64'(1));
      @(posedge clk);
      #1;
      acc       = cyc;
      req_valid = 1'b0;
      snap_ipi  = ipi;
      chk("rsp_latency", 64'(rsp_valid), 64'(1));
      chk("ready_in_resp", 64'(req_ready), 64'(0));
      rd        = rsp_rdata;
      er        = rsp_error;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
   endtask

   task automatic wr32(input logic [15:0] a, input logic [31:0] d,
                       output int acc);
      logic [31:0] rd;
      logic        er;
      bus(1'b1, a, d, rd, er, acc);
      chk("wr_err", 64'(er), 64'(0));
      chk("wr_rdata", 64'(rd), 64'(0));
   endtask

   task automatic rd_chk(input string tag, input logic [15:0] a,
                         input logic [31:0] exp);
      logic [31:0] rd;
      logic        er;
      int          acc;
      bus(1'b0, a, 32'h0, rd, er, acc);
      chk(tag, 64'(rd), 64'(exp));
      chk({tag, "_err"}, 64'(er), 64'(0));
   endtask

   task automatic rd_err(input string tag, input logic [15:0] a);
      logic [31:0] rd;
      logic        er;
      int          acc;
      bus(1'b0, a, 32'h0, rd, er, acc);
      chk(tag, 64'(er), 64'(1));
      chk({tag, "_rdata"}, 64'(rd), 64'(0));
   endtask

   task automatic set_mtime(input logic [63:0] v);
      int acc;
      wr32(CTRL, 32'h0, acc);
      wr32(MLO, v[31:0], acc);
      wr32(MHI, v[63:32], acc);
      m_mtime = v;
   endtask

   task automatic set_cmp(input int h, input logic [63:0] v);
      int acc;
      wr32(cmp_addr(h, 0), v[31:0], acc);
      wr32(cmp_addr(h, 1), v[63:32], acc);
      m_cmp[h] = v;
   endtask

   task automatic run(input int p);
      wr32(CTRL, {16'(p), 14'b0, 1'b1, 1'b1}, ec);
      ps = p;
   endtask

   task automatic freeze();
      int ed;
      wr32(CTRL, 32'h0, ed);
      m_mtime = mt_at(ed);
   endtask

   task automatic check_all(input string tag);
      rd_chk({tag, "_lo"}, MLO, m_mtime[31:0]);
      rd_chk({tag, "_hi"}, MHI, m_mtime[63:32]);
      chk({tag, "_irq"}, 64'(timer_irq), 64'(irq_model(m_mtime)));
      chk({tag, "_ipi"}, 64'(ipi), 64'(m_msip));
   endtask

   initial begin
      logic [31:0] rd;
      logic        er;
      logic [63:0] v, cur;
      int          acc, p, c, h, npulse;

      rst = 1'b1;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      rsp_ready = 1'b0;
      rtc       = 1'b0;
      ec = 0;
      ps = 0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      m_mtime = '0;
      m_msip  = '0;
      for (int i = 0; i < N; i++) m_cmp[i] = '1;

      // reset state
      chk("rst_irq", 64'(timer_irq), 64'(0));
      chk("rst_ipi", 64'(ipi), 64'(0));
      chk("rst_req_ready", 64'(req_ready), 64'(1));
      chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("rst_rdata", 64'(rsp_rdata), 64'(0));
      chk("rst_error", 64'(rsp_error), 64'(0));
      rd_chk("ctrl_rst", CTRL, 32'h0000_0001);
      rd_chk("cmp0_rst", 16'h4000, 32'hFFFF_FFFF);
      rd_chk("cmp32_hi_rst", cmp_addr(32, 1), 32'hFFFF_FFFF);
      rd_chk("mtime_rst", MLO, 32'h0);

      // unused ctrl bits read zero
      wr32(CTRL, 32'h0003_FFFC, acc);
      rd_chk("ctrl_mask", CTRL, 32'h0003_0000);

      // random mtimecmp readback, kept far above mtime
      for (int k = 0; k < 4; k++) begin
         h = int'($urandom_range(6, N - 1));
         v = {$urandom | 32'h1, $urandom};
         set_cmp(h, v);
         rd_chk("cmp_rb_lo", cmp_addr(h, 0), v[31:0]);
         rd_chk("cmp_rb_hi", cmp_addr(h, 1), v[63:32]);
      end

      // unmapped and misaligned accesses
      rd_err("err_2000", 16'h2000);
      rd_err("err_msip33", 16'h0084);
      rd_err("err_cmp33", cmp_addr(N, 0));
      rd_err("err_c004", 16'hC004);
      bus(1'b1, 16'hBFF6, 32'h1234_5678, rd, er, acc);
      chk("err_wr_mis", 64'(er), 64'(1));
      check_all("err_nochange");

      // msip[32] set / misaligned read / clear
      wr32(16'h0080, 32'hFFFF_FFFF, acc);
      chk("ipi_before", 64'(snap_ipi[32]), 64'(0));
      chk("ipi_rise", 64'(ipi[32]), 64'(1));
      m_msip[32] = 1'b1;
      rd_chk("msip_rb", 16'h0080, 32'h1);
      rd_err("err_0082", 16'h0082);
      chk("ipi_hold", 64'(ipi), 64'(m_msip));
      wr32(16'h0080, 32'hFFFF_FFFE, acc);
      chk("ipi_still", 64'(snap_ipi[32]), 64'(1));
      chk("ipi_fall", 64'(ipi[32]), 64'(0));
      m_msip[32] = 1'b0;

      // clk source with prescaler, irq on hart 5
      p = int'($urandom_range(1, 4));
      c = int'($urandom_range(3, 12));
      set_mtime(64'h0);
      set_cmp(5, 64'(c));
      run(p);
      while (cyc <= ec + (p + 1) * (c + 2)) begin
         chk("irq_run", 64'(timer_irq), 64'(irq_model(mt_at(cyc - 1))));
         @(posedge clk);
         #1;
      end
      chk("irq5_set", 64'(timer_irq[5]), 64'(1));
      freeze();
      check_all("presc");

      // low-to-high carry while running
      set_mtime({32'h0, 32'hFFFF_FFFF});
      run(0);
      bus(1'b0, MHI, 32'h0, rd, er, acc);
      cur = mt_at(acc - 1);
      chk("carry_hi", 64'(rd), 64'(cur[63:32]));
      bus(1'b0, MLO, 32'h0, rd, er, acc);
      cur = mt_at(acc - 1);
      chk("carry_lo", 64'(rd), 64'(cur[31:0]));
      freeze();
      check_all("carry");

      // 64-bit wrap drops irq of hart 1
      set_mtime(64'hFFFF_FFFF_FFFF_FFFD);
      set_cmp(1, 64'd5);
      chk("wrap_pre_irq", 64'(timer_irq), 64'(irq_model(m_mtime)));
      run(0);
      repeat (2) @(posedge clk);
      #1;
      freeze();
      check_all("wrap");
      chk("wrap_irq1", 64'(timer_irq[1]), 64'(0));

      // rtc source: latency and one increment per rising edge
      v = {$urandom & 32'h7FFF_FFFF, $urandom};
      set_mtime(v);
      set_cmp(0, v + 64'd1);
      wr32(CTRL, 32'h1, acc);
      repeat (3) @(posedge clk);
      npulse = int'($urandom_range(3, 7));
      @(negedge clk);
      rtc = 1'b1;
      for (int j = 1; j <= S + 2; j++) begin
         @(posedge clk);
         #1;
         chk("rtc_latency", 64'(timer_irq[0]), 64'(j == S + 2));
      end
      @(negedge clk);
      rtc = 1'b0;
      repeat (5) @(negedge clk);
      for (int k = 1; k < npulse; k++) begin
         rtc = 1'b1;
         repeat (5) @(negedge clk);
         rtc = 1'b0;
         repeat (5) @(negedge clk);
      end
      wr32(CTRL, 32'h0, acc);
      m_mtime = v + 64'(npulse);
      check_all("rtc_count");
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         rtc = 1'b1;
         repeat (5) @(negedge clk);
         rtc = 1'b0;
         repeat (5) @(negedge clk);
      end
      check_all("rtc_frozen");

      // response stall: rsp held, no new accept
      @(negedge clk);
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = cmp_addr(5, 0);
      @(posedge clk);
      #1;
      req_addr  = MHI;
      for (int k = 0; k < 5; k++) begin
         chk("stall_valid", 64'(rsp_valid), 64'(1));
         chk("stall_ready", 64'(req_ready), 64'(0));
         chk("stall_rdata", 64'(rsp_rdata), 64'(m_cmp[5][31:0]));
         chk("stall_err", 64'(rsp_error), 64'(0));
         @(posedge clk);
         #1;
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      chk("stall_done", 64'(rsp_valid), 64'(0));

      // write to mtime low coinciding with an increment
      set_mtime({$urandom, $urandom & 32'h0FFF_FFFF});
      run(0);
      v = {32'h0, $urandom};
      wr32(MLO, v[31:0], acc);
      cur = mt_at(acc - 1);
      m_mtime = {cur[63:32], v[31:0]};
      ec = acc;
      freeze();
      check_all("collide");

      // reset during a pending response
      @(negedge clk);
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = CTRL;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      chk("midrst_valid", 64'(rsp_valid), 64'(1));
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("midrst_drop", 64'(rsp_valid), 64'(0));
      chk("midrst_ready", 64'(req_ready), 64'(1));
      chk("midrst_irq", 64'(timer_irq), 64'(0));
      m_mtime = '0;
      m_msip  = '0;
      for (int i = 0; i < N; i++) m_cmp[i] = '1;
      rd_chk("midrst_ctrl", CTRL, 32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
